// File: rtl/carryadder_pkg.sv
// Shared types and helpers for the slice-serial adder/subtractor.
package carryadder_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic {
        MODE_ADD,
        MODE_SUB
    } mode_t;

    // Slice counter width; a single-slice configuration still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned nslices);
        return (nslices > 1) ? $clog2(nslices) : 1;
    endfunction

endpackage

// File: rtl/carryadder_sliced_adder_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its MSB.
module adder_slice #(
    parameter int unsigned SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic c;

    always_comb begin
        c    = cin;
        sum  = '0;
        cmsb = 1'b0;
        for (int unsigned i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) cmsb = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/carryadder_sliced.sv
// Slice-serial ripple-carry adder/subtractor: one SLICE-bit slice per enabled cycle, LSB first.
module carryadder_sliced
    import carryadder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             rx_enable,
    input  logic             rx_write,
    input  logic             rx_strobe,
    input  logic             rx_mode,
    input  logic             rx_carryflag,
    input  logic [WIDTH-1:0] rx_addend0,
    input  logic [WIDTH-1:0] rx_addend1,
    output logic [WIDTH-1:0] tx_sum,
    output logic             tx_carryflag,
    output logic             tx_zeroflag,
    output logic             tx_overflowflag,
    output logic             tx_negflag,
    output logic             tx_ready,
    output logic             tx_done
);

    localparam int unsigned NSLICES = WIDTH / SLICE;
    localparam int unsigned CW      = cnt_width(NSLICES);

    state_t           state;
    mode_t            mode;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] next_work;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sum;
    logic             s_cout;
    logic             s_cmsb;
    logic             last;

    assign last = (cnt == CW'(NSLICES - 1));

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned k = 0; k < NSLICES; k++) begin
            if (cnt == CW'(k)) begin
                a_sl = op_a[k*SLICE +: SLICE];
                b_sl = op_b[k*SLICE +: SLICE];
            end
        end
    end

    adder_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_sl),
        .b    ((mode == MODE_SUB) ? ~b_sl : b_sl),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout),
        .cmsb (s_cmsb)
    );

    // Working sum with the current slice merged in, so the commit sees the final slice.
    always_comb begin
        next_work = work;
        for (int unsigned k = 0; k < NSLICES; k++) begin
            if (cnt == CW'(k)) next_work[k*SLICE +: SLICE] = s_sum;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state           <= IDLE;
            mode            <= MODE_ADD;
            cnt             <= '0;
            carry           <= 1'b0;
            op_a            <= '0;
            op_b            <= '0;
            work            <= '0;
            tx_sum          <= '0;
            tx_carryflag    <= 1'b0;
            tx_zeroflag     <= 1'b1;
            tx_overflowflag <= 1'b0;
            tx_negflag      <= 1'b0;
            tx_ready        <= 1'b1;
            tx_done         <= 1'b0;
        end else begin
            // tx_done is a pulse and drops even when rx_enable is low.
            tx_done <= 1'b0;
            if (rx_enable) begin
                case (state)
                    IDLE: begin
                        if (rx_write) begin
                            op_a <= rx_addend0;
                            op_b <= rx_addend1;
                            mode <= rx_mode ? MODE_SUB : MODE_ADD;
                        end else if (rx_strobe) begin
                            state    <= RUN;
                            tx_ready <= 1'b0;
                            cnt      <= '0;
                            carry    <= (mode == MODE_SUB) ? ~rx_carryflag : rx_carryflag;
                            work     <= '0;
                        end
                    end
                    RUN: begin
                        work  <= next_work;
                        carry <= s_cout;
                        if (last) begin
                            state           <= IDLE;
                            tx_ready        <= 1'b1;
                            tx_done         <= 1'b1;
                            cnt             <= '0;
                            tx_sum          <= next_work;
                            tx_carryflag    <= (mode == MODE_SUB) ? ~s_cout : s_cout;
                            tx_overflowflag <= s_cmsb ^ s_cout;
                            tx_zeroflag     <= (next_work == '0);
                            tx_negflag      <= next_work[WIDTH-1];
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_carryadder_sliced.sv
// Self-checking bench for carryadder_sliced: vector table plus scoreboard of expected results.
module tb_carryadder_sliced;

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        z;
        logic        v;
        logic        n;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic        cin;
        res_t        r;
    } vec_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        rx_enable;
    logic        rx_write;
    logic        rx_strobe;
    logic        rx_mode;
    logic        rx_carryflag;
    logic [15:0] rx_addend0;
    logic [15:0] rx_addend1;
    logic [15:0] tx_sum;
    logic        tx_carryflag;
    logic        tx_zeroflag;
    logic        tx_overflowflag;
    logic        tx_negflag;
    logic        tx_ready;
    logic        tx_done;

    int checks = 0;
    int errors = 0;
    res_t sb[$];
    vec_t vecs[7];

    always #5 aclk = ~aclk;

    carryadder_sliced #(.WIDTH(16), .SLICE(2)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .rx_enable       (rx_enable),
        .rx_write        (rx_write),
        .rx_strobe       (rx_strobe),
        .rx_mode         (rx_mode),
        .rx_carryflag    (rx_carryflag),
        .rx_addend0      (rx_addend0),
        .rx_addend1      (rx_addend1),
        .tx_sum          (tx_sum),
        .tx_carryflag    (tx_carryflag),
        .tx_zeroflag     (tx_zeroflag),
        .tx_overflowflag (tx_overflowflag),
        .tx_negflag      (tx_negflag),
        .tx_ready        (tx_ready),
        .tx_done         (tx_done)
    );

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic m, input logic cin);
        logic [16:0] full;
        res_t r;
        if (m) begin
            full = {1'b0, a} + {1'b0, ~b} + {16'd0, ~cin};
            r.c  = ~full[16];
            r.v  = (a[15] != b[15]) && (full[15] != a[15]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            r.c  = full[16];
            r.v  = (a[15] == b[15]) && (full[15] != a[15]);
        end
        r.sum = full[15:0];
        r.z   = (full[15:0] == 16'd0);
        r.n   = full[15];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every tx_done must match the oldest outstanding expectation.
    always @(negedge aclk) begin
        if (tx_done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got sum %0h with no operation outstanding", tx_sum);
            end else begin
                res_t e;
                e = sb.pop_front();
                if ({tx_sum, tx_carryflag, tx_zeroflag, tx_overflowflag, tx_negflag} !== e) begin
                    errors++;
                    $display("FAIL result: got sum=%h C=%b Z=%b V=%b N=%b expected sum=%h C=%b Z=%b V=%b N=%b",
                             tx_sum, tx_carryflag, tx_zeroflag, tx_overflowflag, tx_negflag,
                             e.sum, e.c, e.z, e.v, e.n);
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] b, input logic m);
        rx_write   = 1'b1;
        rx_addend0 = a;
        rx_addend1 = b;
        rx_mode    = m;
        tick();
        rx_write   = 1'b0;
    endtask

    task automatic do_strobe(input logic cin);
        rx_strobe    = 1'b1;
        rx_carryflag = cin;
        tick();
        rx_strobe    = 1'b0;
    endtask

    // Counts cycles from the strobe edge to tx_done; optional rx_enable stall window.
    task automatic wait_done(input int stall_after, input int stall_len, output int lat);
        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            rx_enable = !(cyc > stall_after && cyc <= stall_after + stall_len);
            tick();
            if (tx_done === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        rx_enable = 1'b1;
    endtask

    initial begin
        int lat;
        int seen;
        logic [15:0] ra, rb;
        logic rm, rc;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{16'h0001, 16'h0002, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{16'h7FFF, 16'h0000, 1'b0, 1'b1, '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1}};
        vecs[5] = '{16'h0005, 16'h0005, 1'b1, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}};

        aresetn      = 1'b0;
        rx_enable    = 1'b1;
        rx_write     = 1'b0;
        rx_strobe    = 1'b0;
        rx_mode      = 1'b0;
        rx_carryflag = 1'b0;
        rx_addend0   = '0;
        rx_addend1   = '0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();

        check("reset_sum", tx_sum, 16'h0000);
        check("reset_flags", {tx_carryflag, tx_zeroflag, tx_overflowflag, tx_negflag}, 4'b0100);
        check("reset_ready_done", {tx_ready, tx_done}, 2'b10);

        foreach (vecs[i]) begin
            do_write(vecs[i].a, vecs[i].b, vecs[i].m);
            sb.push_back(vecs[i].r);
            do_strobe(vecs[i].cin);
            check("ready_low_in_run", tx_ready, 1'b0);
            wait_done(0, 0, lat);
            check("latency", lat, 8);
            check("ready_after_commit", tx_ready, 1'b1);
            tick();
            check("done_one_cycle", tx_done, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            do_write(ra, rb, rm);
            sb.push_back(model(ra, rb, rm, rc));
            do_strobe(rc);
            wait_done(0, 0, lat);
            check("latency_rand", lat, 8);
        end

        // Back-to-back: strobe in the first cycle tx_ready is high.
        do_write(16'h1234, 16'h0F0F, 1'b0);
        sb.push_back(model(16'h1234, 16'h0F0F, 1'b0, 1'b0));
        do_strobe(1'b0);
        wait_done(0, 0, lat);
        check("b2b_first_latency", lat, 8);
        sb.push_back(model(16'h1234, 16'h0F0F, 1'b0, 1'b1));
        do_strobe(1'b1);
        check("b2b_accepted", tx_ready, 1'b0);
        wait_done(0, 0, lat);
        check("b2b_second_latency", lat, 8);

        // Stall: three disabled cycles mid-RUN add three cycles of latency.
        do_write(16'hA5A5, 16'h5A5B, 1'b1);
        sb.push_back(model(16'hA5A5, 16'h5A5B, 1'b1, 1'b0));
        do_strobe(1'b0);
        wait_done(2, 3, lat);
        check("stall_latency", lat, 11);

        // Write and strobe during RUN are ignored.
        do_write(16'h4321, 16'h0101, 1'b0);
        sb.push_back(model(16'h4321, 16'h0101, 1'b0, 1'b0));
        do_strobe(1'b0);
        tick();
        rx_write   = 1'b1;
        rx_strobe  = 1'b1;
        rx_addend0 = 16'hFFFF;
        rx_addend1 = 16'hFFFF;
        rx_mode    = 1'b1;
        tick();
        rx_write   = 1'b0;
        rx_strobe  = 1'b0;
        wait_done(0, 0, lat);
        check("run_ignore_latency", lat + 2, 8);
        sb.push_back(model(16'h4321, 16'h0101, 1'b0, 1'b1));
        do_strobe(1'b1);
        wait_done(0, 0, lat);
        check("operands_kept_latency", lat, 8);

        // Simultaneous write and strobe in IDLE: write wins, no start.
        rx_write   = 1'b1;
        rx_strobe  = 1'b1;
        rx_addend0 = 16'h0300;
        rx_addend1 = 16'h0045;
        rx_mode    = 1'b0;
        tick();
        rx_write   = 1'b0;
        rx_strobe  = 1'b0;
        check("write_wins_ready0", tx_ready, 1'b1);
        tick();
        check("write_wins_ready1", tx_ready, 1'b1);
        sb.push_back(model(16'h0300, 16'h0045, 1'b0, 1'b0));
        do_strobe(1'b0);
        wait_done(0, 0, lat);
        check("write_wins_latency", lat, 8);

        // Reset at slice 3 abandons the operation without a commit.
        do_write(16'h1111, 16'h2222, 1'b0);
        do_strobe(1'b0);
        repeat (3) tick();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        check("rst_mid_ready", tx_ready, 1'b1);
        check("rst_mid_sum", tx_sum, 16'h0000);
        check("rst_mid_zero", tx_zeroflag, 1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tx_done === 1'b1) seen++;
        end
        check("rst_mid_no_done", seen, 0);

        tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
